// File: rtl/four_bit_seq_shifter.sv
// Multi-cycle 4-bit shift/rotate: one position per clock, amt (0-3) steps, start/done handshake.
// Done pulses amt+1 cycles after the accept edge; start is ignored unless idle, so there is no queuing.
module four_bit_seq_shifter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [2:0] mode,
    input  logic [1:0] amt,
    output logic [3:0] r,
    output logic       cout,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] r_nxt;
    logic       cout_nxt;
    logic [2:0] mode_q;
    logic [2:0] mode_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            r      <= 4'b0000;
            cout   <= 1'b0;
            mode_q <= 3'b000;
            cnt    <= 2'd0;
        end else begin
            state  <= state_nxt;
            r      <= r_nxt;
            cout   <= cout_nxt;
            mode_q <= mode_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        cout_nxt  = cout;
        mode_nxt  = mode_q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    r_nxt     = a;
                    cout_nxt  = 1'b0;
                    mode_nxt  = mode;
                    cnt_nxt   = amt;
                    state_nxt = (amt == 2'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Hold modes (000, 111) still burn amt cycles but leave r/cout alone.
                case (mode_q)
                    3'b001, 3'b110: begin
                        r_nxt    = {r[2:0], 1'b0};
                        cout_nxt = r[3];
                    end
                    3'b010: begin
                        r_nxt    = {1'b0, r[3:1]};
                        cout_nxt = r[0];
                    end
                    3'b011: begin
                        r_nxt    = {r[3], r[3:1]};
                        cout_nxt = r[0];
                    end
                    3'b100: begin
                        r_nxt    = {r[2:0], r[3]};
                        cout_nxt = r[3];
                    end
                    3'b101: begin
                        r_nxt    = {r[0], r[3:1]};
                        cout_nxt = r[0];
                    end
                    default: begin
                        r_nxt    = r;
                        cout_nxt = cout;
                    end
                endcase
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_four_bit_seq_shifter.sv
// Bench for four_bit_seq_shifter: per-cycle comparison against a frame-queue model plus directed literal checks.
module tb_four_bit_seq_shifter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [2:0] mode;
    logic [1:0] amt;
    logic [3:0] r;
    logic       cout;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    four_bit_seq_shifter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .mode  (mode),
        .amt   (amt),
        .r     (r),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] r;
        logic       c;
        logic       b;
        logic       d;
    } frame_t;

    frame_t q[$];
    frame_t cur;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One step of the operation on an integer value 0..15; returns {carry, value}.
    function automatic logic [4:0] step(input int x, input int m, input int c);
        int nx;
        int nc;
        nx = x;
        nc = c;
        case (m)
            1, 6: begin nx = (x * 2) % 16;              nc = x / 8; end
            2:    begin nx = x / 2;                     nc = x % 2; end
            3:    begin nx = x / 2 + (x / 8) * 8;       nc = x % 2; end
            4:    begin nx = (x * 2) % 16 + x / 8;      nc = x / 8; end
            5:    begin nx = x / 2 + (x % 2) * 8;       nc = x % 2; end
            default: begin nx = x;                      nc = c; end
        endcase
        return {nc[0], nx[3:0]};
    endfunction

    // Model: an accepted request expands into the list of output frames it will produce.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur = '0;
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else if (cur.d) begin
            cur.d = 1'b0;
        end else if (start) begin
            int x;
            int c;
            logic [4:0] s;
            x = int'(a);
            c = 0;
            for (int i = 0; i < int'(amt); i++) begin
                q.push_back({x[3:0], c[0], 1'b1, 1'b0});
                s = step(x, int'(mode), c);
                x = int'(s[3:0]);
                c = int'(s[4]);
            end
            q.push_back({x[3:0], c[0], 1'b0, 1'b1});
            cur = q.pop_front();
        end
    end

    always @(negedge clk) begin
        chk("model_cmp {r,cout,busy,done}", int'({r, cout, busy, done}), int'(cur));
    end

    task automatic req(input logic [3:0] ia, input logic [2:0] im, input logic [1:0] iamt);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        mode  = im;
        amt   = iamt;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic [3:0] er, input logic ec,
                             input int eb, input bit poke);
        int  n;
        int  bc;
        bit  seen;
        n    = 0;
        bc   = 0;
        seen = 1'b0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) bc++;
                if (poke && bc == 1) begin
                    start = 1'b1;
                    a     = 4'hF;
                    mode  = 3'b001;
                    amt   = 2'd0;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within 12 cycles", name);
        end else begin
            chk({name, " r"},         int'(r),     int'(er));
            chk({name, " cout"},      int'(cout),  int'(ec));
            chk({name, " busy_cyc"},  bc,          eb);
            chk({name, " model_r"},   int'(cur.r), int'(er));
            chk({name, " model_c"},   int'(cur.c), int'(ec));
            chk({name, " latency"},   n,           eb + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = 4'h0;
        mode  = 3'b000;
        amt   = 2'd0;
        #12 rst_n = 1'b1;
        @(negedge clk);
        chk("reset r",    int'(r),    0);
        chk("reset cout", int'(cout), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);

        req(4'b0101, 3'b001, 2'd1); wait_done("lsl1",   4'b1010, 1'b0, 1, 1'b0);
        req(4'b1010, 3'b011, 2'd2); wait_done("asr2",   4'b1110, 1'b1, 2, 1'b0);
        req(4'b0111, 3'b100, 2'd3); wait_done("rol3",   4'b1011, 1'b1, 3, 1'b0);
        req(4'b1100, 3'b010, 2'd3); wait_done("lsr3",   4'b0001, 1'b1, 3, 1'b0);
        req(4'b1100, 3'b010, 2'd0); wait_done("amt0",   4'b1100, 1'b0, 0, 1'b0);
        req(4'b1100, 3'b111, 2'd2); wait_done("rsv2",   4'b1100, 1'b0, 2, 1'b0);
        req(4'b0011, 3'b101, 2'd3); wait_done("ignore", 4'b0110, 1'b0, 3, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold r after done", int'(r), 4'b0110);

        // Asynchronous reset in the middle of a shift.
        req(4'b0011, 3'b101, 2'd3);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst r",    int'(r),    0);
        chk("midrst cout", int'(cout), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        @(negedge clk);
        #3 rst_n = 1'b1;
        req(4'b1001, 3'b001, 2'd2); wait_done("after_rst", 4'b0100, 1'b0, 2, 1'b0);

        // Random traffic; the negedge comparator checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a     = 4'($urandom);
            mode  = 3'($urandom);
            amt   = 2'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bit_seq_shifter.md
# four_bit_seq_shifter

Multi-cycle 4-bit shift/rotate engine that applies a shift of 0–3 positions, one position per clock, under a start/done handshake. It is the sequential counterpart to the combinational 4-bit shifter. It serves datapaths that issue a shift request, wait for completion, and read a registered result plus the last bit shifted out. The result is held stable after completion until the next accepted request.

## Interface
- No parameters; width fixed at 4 bits, shift amount fixed at 2 bits.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `start`  input  1  request strobe; sampled only in IDLE.
- `a`  input  4  operand; captured when `start` is accepted.
- `mode`  input  3  operation select; captured with `a`.
- `amt`  input  2  shift count 0–3; captured with `a`.
- `r`  output  4  result register.
- `cout`  output  1  last bit shifted or rotated out.
- `busy`  output  1  high while in SHIFT.
- `done`  output  1  one-cycle completion pulse.

## Operation
- Mode encoding (one position per step):
  - 000: hold, no change.
  - 001: logical left; LSB←0, cout←r[3].
  - 010: logical right; MSB←0, cout←r[0].
  - 011: arithmetic right; MSB←r[3], cout←r[0].
  - 100: rotate left; r[0]←r[3], cout←r[3].
  - 101: rotate right; r[3]←r[0], cout←r[0].
  - 110: arithmetic left; identical to 001.
  - 111: reserved; behaves as 000.
- FSM states and transitions:
  - IDLE: on `start`=1, load `r`←`a`, `cout`←0, latch `mode`, load `cnt`←`amt`. Go to DONE if `amt`=0, else SHIFT.
  - SHIFT: each edge applies one step to `r`/`cout` and decrements `cnt`. Step at `cnt`=1 transitions to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; no queuing. Operand inputs are don't-care outside the accepting edge.
- In modes 000/111 with `amt`>0, FSM still runs `amt` steps. `r` is unchanged and `cout` stays 0.
- `r` and `cout` hold their final values through DONE and IDLE until the next accepted `start`.
- `cout` is 0 whenever `amt`=0.
- `busy` is 1 only in SHIFT; `done` is 1 only in DONE; the two are never high together.

## Timing
- Reset: state IDLE; `r`=0000, `cout`=0, `busy`=0, `done`=0, `cnt`=0.
- Reset is asynchronous: outputs clear immediately on `rst_n` falling, independent of `clk`.
- Reset mid-operation aborts the request; no `done` pulse is produced.
- First accepted `start` is the first edge with `rst_n`=1 and `start`=1 in IDLE.
- Request accepted at edge k:
  - DONE is entered at edge k+`amt`, with `amt`=0 entering DONE at edge k.
  - `done` is high for the cycle following that edge.
  - IDLE is re-entered at the next edge.
- `busy` is high for exactly `amt` cycles, starting after edge k.
- Back-to-back throughput: next `start` accepted at edge k+`amt`+2 at the earliest (one IDLE cycle between requests).
- Intermediate `r` values during SHIFT are visible but not guaranteed meaningful to consumers. Only the value at `done` is architectural.

## Test plan
- `a`=0101, `mode`=001, `amt`=1 → `done` one cycle after accept edge +1, `r`=1010, `cout`=0, `busy` high 1 cycle.
- `a`=1010, `mode`=011, `amt`=2 → intermediate 1101, final `r`=1110, `cout`=1, `done` after edge k+2.
- `a`=0111, `mode`=100, `amt`=3 → sequence 1110, 1101, 1011; final `r`=1011, `cout`=1. Then `a`=1100, `mode`=010, `amt`=3 → `r`=0001, `cout`=1.
- `a`=1100, `mode`=010, `amt`=0 → DONE at accept edge, `busy` never high, `r`=1100, `cout`=0. Repeat with `mode`=111, `amt`=2 → `r`=1100, `cout`=0, `busy` high 2 cycles.
- Start ignored while busy: `a`=0011, `mode`=101, `amt`=3, then `start` pulsed with `a`=1111 during SHIFT → final `r`=0110, `cout`=0, single `done`.
- Reset mid-operation: drop `rst_n` during SHIFT → `r`=0000, `cout`=0, `busy`=0 immediately, no `done`. The next request after release completes normally.
